// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared combinational ALU
//
// Purpose:
//    Grants one of two requesters access to an external combinational ALU,
//    holds the winning operation stable for one EXEC cycle, captures the ALU
//    result and presents it on a valid/ready response port.
//
// Ports:
//    clk_i, rst_i                   clock, asynchronous active-low reset
//    reqN_valid_i / reqN_ready_o    requester N handshake (N = 0, 1)
//    reqN_aluop_i, reqN_funct_i     requester N ALU control fields
//    reqN_src1_i, reqN_src2_i       requester N operands
//    alu_aluop_o, alu_funct_o       latched control fields to the ALU controller
//    alu_src1_o, alu_src2_o         latched operands to the ALU
//    alu_result_i, alu_zero_i       combinational ALU outputs
//    rsp_valid_o / rsp_ready_i      response handshake
//    rsp_id_o, rsp_result_o,        winning requester, captured result and zero flag
//    rsp_zero_o

module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [2:0]        req0_aluop_i,
   input  logic [5:0]        req0_funct_i,
   input  logic [DATA_W-1:0] req0_src1_i,
   input  logic [DATA_W-1:0] req0_src2_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [2:0]        req1_aluop_i,
   input  logic [5:0]        req1_funct_i,
   input  logic [DATA_W-1:0] req1_src1_i,
   input  logic [DATA_W-1:0] req1_src2_i,
   output logic [2:0]        alu_aluop_o,
   output logic [5:0]        alu_funct_o,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [DATA_W-1:0] alu_src2_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic              alu_zero_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic              rsp_id_o,
   output logic [DATA_W-1:0] rsp_result_o,
   output logic              rsp_zero_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]        r_state;
   logic              r_last_grant;
   logic [2:0]        r_aluop;
   logic [5:0]        r_funct;
   logic [DATA_W-1:0] r_src1;
   logic [DATA_W-1:0] r_src2;
   logic              r_id;
   logic [DATA_W-1:0] r_result;
   logic              r_zero;

   logic w_idle;
   logic w_grant0;
   logic w_grant1;
   logic w_xfer;

   // Reset forces r_state to IDLE, so the reset level itself must also gate
   // the grants; otherwise ready could rise while reset is still held.
   assign w_idle   = (r_state == S_IDLE) && rst_i;

   // A contested cycle goes to whichever requester did not win last time.
   assign w_grant0 = w_idle && req0_valid_i && (!req1_valid_i || r_last_grant);
   assign w_grant1 = w_idle && req1_valid_i && (!req0_valid_i || !r_last_grant);
   assign w_xfer   = w_grant0 || w_grant1;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_aluop      <= '0;
         r_funct      <= '0;
         r_src1       <= '0;
         r_src2       <= '0;
         r_id         <= 1'b0;
         r_result     <= '0;
         r_zero       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_aluop      <= w_grant1 ? req1_aluop_i : req0_aluop_i;
                  r_funct      <= w_grant1 ? req1_funct_i : req0_funct_i;
                  r_src1       <= w_grant1 ? req1_src1_i  : req0_src1_i;
                  r_src2       <= w_grant1 ? req1_src2_i  : req0_src2_i;
                  r_id         <= w_grant1;
                  r_last_grant <= w_grant1;
                  r_state      <= S_EXEC;
               end
            end
            S_EXEC: begin
               // The ALU has had a full cycle of stable operands by now.
               r_result <= alu_result_i;
               r_zero   <= alu_zero_i;
               r_state  <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready_i) begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign req0_ready_o = w_grant0;
   assign req1_ready_o = w_grant1;

   assign alu_aluop_o  = r_aluop;
   assign alu_funct_o  = r_funct;
   assign alu_src1_o   = r_src1;
   assign alu_src2_o   = r_src2;

   assign rsp_valid_o  = (r_state == S_RESP);
   assign rsp_id_o     = r_id;
   assign rsp_result_o = r_result;
   assign rsp_zero_o   = r_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter

module tb_alu_arbiter;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]    req0_aluop, req1_aluop, alu_aluop;
   logic [5:0]    req0_funct, req1_funct, alu_funct;
   logic [W-1:0]  req0_src1, req0_src2, req1_src1, req1_src2;
   logic [W-1:0]  alu_src1, alu_src2, alu_result, rsp_result;
   logic          alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(W)) dut (
      .clk_i(clk), .rst_i(rst_n),
      .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
      .req0_aluop_i(req0_aluop), .req0_funct_i(req0_funct),
      .req0_src1_i(req0_src1), .req0_src2_i(req0_src2),
      .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
      .req1_aluop_i(req1_aluop), .req1_funct_i(req1_funct),
      .req1_src1_i(req1_src1), .req1_src2_i(req1_src2),
      .alu_aluop_o(alu_aluop), .alu_funct_o(alu_funct),
      .alu_src1_o(alu_src1), .alu_src2_o(alu_src2),
      .alu_result_i(alu_result), .alu_zero_i(alu_zero),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
      .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero)
   );

   // Stand-in for the combinational ALU that sits next to the arbiter.
   function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [5:0] f,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
      case (op)
         3'b000: return a + b;
         3'b001: return a - b;
         3'b010: begin
            case (f)
               6'b100000, 6'b100001: return a + b;
               6'b100010, 6'b100011: return a - b;
               6'b100100: return a & b;
               6'b100101: return a | b;
               6'b100110: return a ^ b;
               6'b100111: return ~(a | b);
               6'b101010: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
               default:   return '0;
            endcase
         end
         3'b011:  return a & b;
         3'b100:  return a | b;
         default: return a ^ b;
      endcase
   endfunction

   assign alu_result = alu_fn(alu_aluop, alu_funct, alu_src1, alu_src2);
   assign alu_zero   = (alu_result == '0);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference: one operation in flight at most, tracked by
   // how many edges have passed since it was accepted.
   bit           m_have;
   int           m_age;
   bit           m_last;
   logic [2:0]   m_aluop;
   logic [5:0]   m_funct;
   logic [W-1:0] m_src1, m_src2, m_res;
   bit           m_id, m_zero;
   int           m_grants[$];

   always @(negedge clk) begin : cmp
      bit e0, e1;
      if (!rst_n) begin
         check("rst_ready0", req0_ready, 0);
         check("rst_ready1", req1_ready, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_rsp_result", rsp_result, 0);
         check("rst_rsp_zero", rsp_zero, 0);
         check("rst_rsp_id", rsp_id, 0);
         check("rst_alu_ops", {alu_aluop, alu_funct, alu_src1, alu_src2}, 0);
         m_have = 0; m_age = 0; m_last = 1;
         m_aluop = '0; m_funct = '0; m_src1 = '0; m_src2 = '0;
      end else begin
         e0 = 0;
         e1 = 0;
         if (!m_have) begin
            if (req0_valid && req1_valid) begin
               e0 = m_last;
               e1 = !m_last;
            end else begin
               e0 = req0_valid;
               e1 = req1_valid;
            end
         end
         check("ready0", req0_ready, e0);
         check("ready1", req1_ready, e1);
         check("rsp_valid", rsp_valid, (m_have && m_age >= 2));
         check("alu_aluop", alu_aluop, m_aluop);
         check("alu_funct", alu_funct, m_funct);
         check("alu_src1", alu_src1, m_src1);
         check("alu_src2", alu_src2, m_src2);
         if (m_have && m_age >= 2) begin
            check("rsp_id", rsp_id, m_id);
            check("rsp_result", rsp_result, m_res);
            check("rsp_zero", rsp_zero, m_zero);
         end
         if (e0 || e1) begin
            m_have  = 1;
            m_age   = 1;
            m_id    = e1;
            m_last  = e1;
            m_aluop = e1 ? req1_aluop : req0_aluop;
            m_funct = e1 ? req1_funct : req0_funct;
            m_src1  = e1 ? req1_src1  : req0_src1;
            m_src2  = e1 ? req1_src2  : req0_src2;
            m_res   = alu_fn(m_aluop, m_funct, m_src1, m_src2);
            m_zero  = (m_res == '0);
            m_grants.push_back(e1 ? 1 : 0);
         end else if (m_have && m_age == 1) begin
            m_age = 2;
         end else if (m_have && rsp_ready) begin
            m_have = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int n, input logic [2:0] op, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      if (n == 0) begin
         req0_valid = 1; req0_aluop = op; req0_funct = f; req0_src1 = a; req0_src2 = b;
      end else begin
         req1_valid = 1; req1_aluop = op; req1_funct = f; req1_src1 = a; req1_src2 = b;
      end
   endtask

   task automatic wait_grant(input int n, input string tag);
      bit got;
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = (n == 0) ? req0_ready : req1_ready;
         if (!got) tick();
      end
      check(tag, got, 1);
      tick();
   endtask

   task automatic wait_rsp(input bit id, input logic [W-1:0] res, input bit z, input string tag);
      bit got;
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk);
         got = rsp_valid;
         if (!got) tick();
      end
      check({tag, "_seen"}, got, 1);
      check({tag, "_id"}, rsp_id, id);
      check({tag, "_result"}, rsp_result, res);
      check({tag, "_zero"}, rsp_zero, z);
      tick();
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int base;
      rst_n = 0; rsp_ready = 1;
      req0_valid = 0; req0_aluop = '0; req0_funct = '0; req0_src1 = '0; req0_src2 = '0;
      req1_valid = 0; req1_aluop = '0; req1_funct = '0; req1_src1 = '0; req1_src2 = '0;
      tick(); tick();
      req0_valid = 1; req1_valid = 1;
      @(negedge clk);
      check("rst_ready_hold", {req0_ready, req1_ready}, 0);
      tick();
      req0_valid = 0; req1_valid = 0; rst_n = 1;

      // Single req0 add 5+3, accepted on the first edge after reset.
      set_req(0, 3'b010, 6'b100000, 5, 3);
      @(negedge clk);
      check("t1_ready0", req0_ready, 1);
      tick();
      req0_valid = 0;
      @(negedge clk);
      check("t1_rsp_early", rsp_valid, 0);
      tick();
      @(negedge clk);
      check("t1_rsp_valid", rsp_valid, 1);
      check("t1_id", rsp_id, 0);
      check("t1_result", rsp_result, 8);
      check("t1_zero", rsp_zero, 0);
      tick();

      // Reset, then both valid: req0 must win first.
      rst_n = 0; tick(); rst_n = 1;
      set_req(0, 3'b010, 6'b100011, 7, 7);
      set_req(1, 3'b010, 6'b100101, 32'hF0, 32'h0F);
      @(negedge clk);
      check("t2_ready0", req0_ready, 1);
      check("t2_ready1", req1_ready, 0);
      tick();
      req0_valid = 0;
      wait_rsp(0, 0, 1, "t2_req0");
      wait_grant(1, "t2_grant1");
      req1_valid = 0;
      wait_rsp(1, 32'hFF, 0, "t2_req1");

      // Both held valid for four transactions.
      base = m_grants.size();
      set_req(0, 3'b010, 6'b100000, $urandom, $urandom);
      set_req(1, 3'b000, 6'b000000, $urandom, $urandom);
      repeat (10) tick();
      req0_valid = 0; req1_valid = 0;
      repeat (4) tick();
      check("t3_count", m_grants.size() - base, 4);
      for (int i = 0; i < 4 && base + i < m_grants.size(); i++)
         check("t3_order", m_grants[base + i], i % 2);

      // Response stall with a req1 that gives up before it is served.
      rsp_ready = 0;
      base = m_grants.size();
      set_req(0, 3'b010, 6'b100100, 32'hFFFF0000, 32'h0FF00FF0);
      wait_grant(0, "t4_grant0");
      req0_valid = 0;
      set_req(1, 3'b001, 6'b000000, 9, 4);
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_stall_valid", rsp_valid, 1);
         check("t4_stall_result", rsp_result, 32'h0FF00000);
         check("t4_stall_ready1", req1_ready, 0);
         tick();
         if (i == 2) req1_valid = 0;
      end
      rsp_ready = 1;
      @(negedge clk);
      check("t4_release_valid", rsp_valid, 1);
      tick();
      @(negedge clk);
      check("t4_idle", rsp_valid, 0);
      check("t4_no_req1", m_grants.size() - base, 1);
      tick();
      set_req(1, 3'b000, 6'b000000, 10, 20);
      wait_grant(1, "t4_grant1");
      req1_valid = 0;
      wait_rsp(1, 30, 0, "t4_req1");

      // Reset during EXEC of a req1 addi.
      set_req(1, 3'b000, 6'b000000, 100, 32'hFFFFFF9C);
      wait_grant(1, "t5_grant1");
      req1_valid = 0;
      rst_n = 0;
      tick();
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_no_rsp", rsp_valid, 0);
         tick();
      end
      set_req(0, 3'b010, 6'b100010, 3, 1);
      set_req(1, 3'b010, 6'b100010, 4, 1);
      @(negedge clk);
      check("t5_ready0", req0_ready, 1);
      check("t5_ready1", req1_ready, 0);
      tick();
      req0_valid = 0; req1_valid = 0;
      repeat (3) tick();

      // Randomised traffic against the reference.
      for (int c = 0; c < 600; c++) begin
         rst_n      = ($urandom_range(0, 149) != 0);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         req0_valid = ($urandom_range(0, 9) < 6);
         req1_valid = ($urandom_range(0, 9) < 6);
         req0_aluop = 3'($urandom_range(0, 7));
         req1_aluop = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
         req0_funct = 6'b100000 | 6'($urandom_range(0, 10));
         req1_funct = 6'b100000 | 6'($urandom_range(0, 10));
         req0_src1  = $urandom; req0_src2 = ($urandom_range(0, 3) == 0) ? req0_src1 : $urandom;
         req1_src1  = $urandom; req1_src2 = $urandom;
         tick();
      end
      rst_n = 1; rsp_ready = 1; req0_valid = 0; req1_valid = 0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
